// File: rtl/svpwm_period_sequencer.sv
// svpwm_period_sequencer: launches the SVPWM calculation once per PWM period.
// Ports: sys_clk/reset; init/run gates; volt valid/ready + U_alpha/U_beta in;
//        U_alpha/U_beta out, cal enable/done, period_start, stale, overrun, timeout.
module svpwm_period_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int PERIOD_CNT = 5000,
    parameter int CAL_OFFSET = 0,
    parameter int DONE_TMO   = 1024
) (
    input  logic                         sys_clk,
    input  logic                         reset,
    input  logic                         system_initilization_done_in,
    input  logic                         run_enable_in,
    input  logic                         volt_valid_in,
    output logic                         volt_ready_out,
    input  logic signed [DATA_WIDTH-1:0] U_alpha_in,
    input  logic signed [DATA_WIDTH-1:0] U_beta_in,
    output logic signed [DATA_WIDTH-1:0] U_alpha_out,
    output logic signed [DATA_WIDTH-1:0] U_beta_out,
    output logic                         svpwm_cal_enable_out,
    input  logic                         svpwm_cal_done_in,
    output logic                         period_start_out,
    output logic                         stale_cmd_out,
    output logic                         overrun_out,
    output logic                         timeout_err_out
);

    localparam int CNT_W = (PERIOD_CNT > 1) ? $clog2(PERIOD_CNT) : 1;
    localparam int TMO_W = $clog2(DONE_TMO + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_TRIG = CNT_W'(CAL_OFFSET);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TMO - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_IDLE,
        S_BUSY
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [TMO_W-1:0]        busy_cnt;
    logic                    stg_full;
    logic [DATA_WIDTH-1:0]   stg_alpha;
    logic [DATA_WIDTH-1:0]   stg_beta;

    logic run_ok;
    logic tick;
    logic busy_done;
    logic busy_tmo;
    logic busy_exit;
    logic launch;
    logic overrun;
    logic xfer;

    assign run_ok    = system_initilization_done_in & run_enable_in;
    assign tick      = run_ok && (state != S_OFF) && (cnt == CNT_TRIG);
    assign busy_done = (state == S_BUSY) && svpwm_cal_done_in;
    // busy_cnt counts BUSY cycles from 0, so the last allowed one is DONE_TMO-1.
    assign busy_tmo  = (state == S_BUSY) && !svpwm_cal_done_in
                       && (busy_cnt == TMO_LAST);
    assign busy_exit = busy_done | busy_tmo;
    // A BUSY exit on the trigger tick retires first, so the tick still launches.
    assign launch    = tick && ((state == S_IDLE) || busy_exit);
    assign overrun   = tick && (state == S_BUSY) && !busy_exit;

    // Launching frees the slot this cycle, so a command can enter alongside it.
    assign volt_ready_out = (state != S_OFF) && (!stg_full || launch);
    assign xfer           = volt_valid_in && volt_ready_out;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state                <= S_OFF;
            cnt                  <= '0;
            busy_cnt             <= '0;
            stg_full             <= 1'b0;
            stg_alpha            <= '0;
            stg_beta             <= '0;
            U_alpha_out          <= '0;
            U_beta_out           <= '0;
            svpwm_cal_enable_out <= 1'b0;
            period_start_out     <= 1'b0;
            stale_cmd_out        <= 1'b0;
            overrun_out          <= 1'b0;
            timeout_err_out      <= 1'b0;
        end else begin
            svpwm_cal_enable_out <= launch;
            stale_cmd_out        <= launch && !stg_full;
            overrun_out          <= overrun;
            period_start_out     <= run_ok && (state != S_OFF) && (cnt == '0);

            if (!run_ok) begin
                // Drop straight to OFF; any in-flight calculation is abandoned.
                state    <= S_OFF;
                cnt      <= '0;
                busy_cnt <= '0;
                stg_full <= 1'b0;
            end else begin
                if ((state == S_OFF) || (cnt == CNT_LAST)) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end

                unique case (state)
                    S_OFF: begin
                        state           <= S_IDLE;
                        timeout_err_out <= 1'b0;
                    end
                    S_IDLE: begin
                        if (launch) begin
                            state    <= S_BUSY;
                            busy_cnt <= '0;
                        end
                    end
                    S_BUSY: begin
                        if (launch) begin
                            busy_cnt <= '0;
                        end else if (busy_exit) begin
                            state <= S_IDLE;
                        end else begin
                            busy_cnt <= busy_cnt + 1'b1;
                        end
                        if (busy_tmo) begin
                            timeout_err_out <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_OFF;
                    end
                endcase

                // Empty slot on launch: outputs keep the previous command.
                if (launch && stg_full) begin
                    U_alpha_out <= stg_alpha;
                    U_beta_out  <= stg_beta;
                end

                if (xfer) begin
                    stg_alpha <= U_alpha_in;
                    stg_beta  <= U_beta_in;
                    stg_full  <= 1'b1;
                end else if (launch) begin
                    stg_full <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_svpwm_period_sequencer.sv
// tb_svpwm_period_sequencer: directed stimulus with a queued scoreboard.
// Expected launches/overruns/timeouts are queued with their cycle and popped by a monitor.
module tb_svpwm_period_sequencer;

    localparam int DW = 16;
    localparam int K_LAUNCH = 1;
    localparam int K_OVR    = 2;
    localparam int K_TMO    = 3;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic          init_done = 1'b0;
    logic          run_en = 1'b0;
    logic          vvalid = 1'b0;
    logic          vready;
    logic [DW-1:0] ua_in = '0;
    logic [DW-1:0] ub_in = '0;
    logic [DW-1:0] ua_out;
    logic [DW-1:0] ub_out;
    logic          cal_en;
    logic          done_auto = 1'b0;
    logic          done_man = 1'b0;
    logic          done;
    logic          period_start;
    logic          stale;
    logic          overrun;
    logic          tmo_err;

    assign done = done_auto | done_man;

    svpwm_period_sequencer #(
        .DATA_WIDTH(DW),
        .PERIOD_CNT(100),
        .CAL_OFFSET(10),
        .DONE_TMO  (150)
    ) dut (
        .sys_clk                     (sys_clk),
        .reset                       (reset),
        .system_initilization_done_in(init_done),
        .run_enable_in               (run_en),
        .volt_valid_in               (vvalid),
        .volt_ready_out              (vready),
        .U_alpha_in                  (ua_in),
        .U_beta_in                   (ub_in),
        .U_alpha_out                 (ua_out),
        .U_beta_out                  (ub_out),
        .svpwm_cal_enable_out        (cal_en),
        .svpwm_cal_done_in           (done),
        .period_start_out            (period_start),
        .stale_cmd_out               (stale),
        .overrun_out                 (overrun),
        .timeout_err_out             (tmo_err)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        int            kind;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          stale;
    } ev_t;

    ev_t  sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   auto_done = 1'b1;
    logic prev_tmo = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int c, input int k, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic s);
        ev_t e;
        e.cyc   = c;
        e.kind  = k;
        e.a     = a;
        e.b     = b;
        e.stale = s;
        sb.push_back(e);
    endtask

    task automatic got(input int k, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic s);
        ev_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none",
                     k, cyc);
        end else begin
            e = sb.pop_front();
            check("ev_cycle", 64'(cyc), 64'(e.cyc));
            check("ev_kind", 64'(k), 64'(e.kind));
            if (k == K_LAUNCH) begin
                check("launch_cmd", 64'({a, b, s}), 64'({e.a, e.b, e.stale}));
            end
        end
    endtask

    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
        check("ready_accept", 64'(vready), 1);
        vvalid = 1'b1;
        ua_in  = a;
        ub_in  = b;
        @(posedge sys_clk);
        #1;
        vvalid = 1'b0;
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!reset) begin
                if (cal_en) got(K_LAUNCH, ua_out, ub_out, stale);
                if (overrun) got(K_OVR, '0, '0, 1'b0);
                if (tmo_err && !prev_tmo) got(K_TMO, '0, '0, 1'b0);
            end
            prev_tmo = tmo_err;
        end
    end

    // SVPWM unit model: done 20 cycles after each enable when allowed.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (cal_en && auto_done && !reset) begin
                repeat (20) @(posedge sys_clk);
                #1 done_auto = 1'b1;
                @(posedge sys_clk);
                #1 done_auto = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int b2;
        int b3;

        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_u", 64'({ua_out, ub_out}), 0);
        check("rst_ready", 64'(vready), 0);
        check("rst_pulses",
              64'({cal_en, period_start, stale, overrun, tmo_err}), 0);
        reset = 1'b0;
        repeat (3) begin
            @(posedge sys_clk);
            #1;
        end
        init_done = 1'b1;
        repeat (3) begin
            @(posedge sys_clk);
            #1;
        end
        check("off_ready", 64'(vready), 0);
        run_en = 1'b1;
        b = cyc + 1;

        // T1: single command, later launches stale
        go(b + 1);
        check("period_start_first", 64'(period_start), 1);
        go(b + 2);
        send(16'h3FFF, 16'h1FFF);
        check("ready_full", 64'(vready), 0);
        expect_ev(b + 11, K_LAUNCH, 16'h3FFF, 16'h1FFF, 1'b0);
        expect_ev(b + 111, K_LAUNCH, 16'h3FFF, 16'h1FFF, 1'b1);
        go(b + 100);
        check("period_start_low", 64'(period_start), 0);
        go(b + 101);
        check("period_start_wrap", 64'(period_start), 1);

        // T2: new command every period
        go(b + 150);
        send(16'h1234, 16'hFEDC);
        expect_ev(b + 211, K_LAUNCH, 16'h1234, 16'hFEDC, 1'b0);
        go(b + 250);
        send(16'h8000, 16'h7FFF);
        check("ready_drop", 64'(vready), 0);
        expect_ev(b + 311, K_LAUNCH, 16'h8000, 16'h7FFF, 1'b0);

        // T4: transfer on the launch cycle
        go(b + 350);
        send(16'h0AAA, 16'h0555);
        expect_ev(b + 411, K_LAUNCH, 16'h0AAA, 16'h0555, 1'b0);
        expect_ev(b + 511, K_LAUNCH, 16'h7123, 16'h8456, 1'b0);
        go(b + 405);
        vvalid = 1'b1;
        ua_in  = 16'h7123;
        ub_in  = 16'h8456;
        check("ready_held_full", 64'(vready), 0);
        go(b + 410);
        check("ready_on_launch", 64'(vready), 1);
        go(b + 411);
        vvalid = 1'b0;

        // T3: done withheld -> overrun, then timeout, then normal launch
        go(b + 540);
        auto_done = 1'b0;
        expect_ev(b + 611, K_LAUNCH, 16'h7123, 16'h8456, 1'b1);
        expect_ev(b + 711, K_OVR, '0, '0, 1'b0);
        go(b + 650);
        send(16'h0001, 16'hFFFF);
        expect_ev(b + 761, K_TMO, '0, '0, 1'b0);
        expect_ev(b + 811, K_LAUNCH, 16'h0001, 16'hFFFF, 1'b0);
        go(b + 760);
        check("tmo_before", 64'(tmo_err), 0);
        go(b + 761);
        check("tmo_set", 64'(tmo_err), 1);

        // T5: run dropped mid-BUSY with a staged command
        go(b + 829);
        send(16'h5555, 16'h2222);
        run_en = 1'b0;
        go(b + 831);
        check("off_ready_drop", 64'(vready), 0);
        check("off_tmo_sticky", 64'(tmo_err), 1);
        go(b + 832);
        done_man = 1'b1;
        go(b + 833);
        done_man = 1'b0;
        go(b + 840);
        run_en = 1'b1;
        auto_done = 1'b1;
        b2 = cyc + 1;
        expect_ev(b2 + 11, K_LAUNCH, 16'h0001, 16'hFFFF, 1'b1);
        go(b2);
        check("tmo_cleared", 64'(tmo_err), 0);
        go(b2 + 1);
        check("period_start_reentry", 64'(period_start), 1);

        // T6: asynchronous reset mid-period
        go(b2 + 30);
        send(16'h6666, 16'h3333);
        go(b2 + 55);
        #2;
        reset = 1'b1;
        init_done = 1'b0;
        #1;
        check("async_rst_u", 64'({ua_out, ub_out}), 0);
        check("async_rst_ready", 64'(vready), 0);
        repeat (3) @(posedge sys_clk);
        #1;
        reset = 1'b0;
        go(b2 + 200);
        check("no_init_ready", 64'(vready), 0);
        init_done = 1'b1;
        b3 = cyc + 1;
        expect_ev(b3 + 11, K_LAUNCH, '0, '0, 1'b1);
        go(b3 + 1);
        check("period_start_reinit", 64'(period_start), 1);
        go(b3 + 40);
        check("sb_empty", 64'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
